// File: rtl/uart_peripheral_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_peripheral_pkg                                                  |
// | Register offsets, CON bit positions and FSM encodings for the UART.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_peripheral_pkg;

    localparam logic [31:0] c_TXD_OFF = 32'd0;
    localparam logic [31:0] c_RXD_OFF = 32'd4;
    localparam logic [31:0] c_CON_OFF = 32'd8;

    localparam int c_CON_IRQ_RX     = 0;
    localparam int c_CON_IRQ_TX     = 1;
    localparam int c_CON_RX_VALID   = 2;
    localparam int c_CON_TX_BUSY    = 3;
    localparam int c_CON_OVERRUN    = 4;
    localparam int c_CON_TXDONE_CLR = 5;

    // Shared by the TX and RX state machines.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_peripheral_baud_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_counter                                                    |
// | Free-running 0..CLKS_PER_BIT-1 bit-period counter with restart.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tc,
    output logic o_half
);

    localparam int              c_CW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_TC   = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF = c_CW'(CLKS_PER_BIT / 2);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_restart || (r_count == c_TC)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_tc   = (r_count == c_TC);
    assign o_half = (r_count == c_HALF);

endmodule
`default_nettype wire

// File: rtl/uart_peripheral.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_peripheral                                                      |
// | Memory-mapped 8N1 UART (TXD/RXD/CON) on the MEM-stage peripheral bus.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_peripheral
    import uart_peripheral_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);

    logic w_hit_txd, w_hit_rxd, w_hit_con;
    logic w_txd_wr, w_con_wr, w_rxd_rd, w_tx_accept, w_tx_busy;
    logic w_tx_tc, w_tx_half_unused, w_rx_tc, w_rx_half, w_rx_restart, w_rx_stop_ok;
    logic w_unused_wdata;
    logic [1:0] r_tx_state, w_tx_state_nxt, r_rx_state, w_rx_state_nxt;
    logic [7:0] r_tx_byte, r_rx_shift, r_rx_data;
    logic [2:0] r_tx_bit, r_rx_bit;
    logic [1:0] r_irq_en;
    logic       r_tx_done, r_rx_valid, r_overrun;
    logic       r_rx_meta, r_rx_sync, r_rx_prev;
    logic [31:0] w_con_word;

    assign w_hit_txd      = (Addr == BASE_ADDR + c_TXD_OFF);
    assign w_hit_rxd      = (Addr == BASE_ADDR + c_RXD_OFF);
    assign w_hit_con      = (Addr == BASE_ADDR + c_CON_OFF);
    assign w_txd_wr       = MemWrite & w_hit_txd;
    assign w_con_wr       = MemWrite & w_hit_con;
    assign w_rxd_rd       = MemRead & w_hit_rxd;
    assign w_tx_busy      = (r_tx_state != c_ST_IDLE);
    assign w_tx_accept    = w_txd_wr & ~w_tx_busy;
    assign w_unused_wdata = ^WriteData[31:8];

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
        .clk       (clk),
        .reset     (reset),
        .i_restart (~w_tx_busy),
        .o_tc      (w_tx_tc),
        .o_half    (w_tx_half_unused)
    );

    // ---------------- transmitter ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_tx_state <= c_ST_IDLE;
        else        r_tx_state <= w_tx_state_nxt;
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            c_ST_IDLE:  if (w_txd_wr) w_tx_state_nxt = c_ST_START;
            c_ST_START: if (w_tx_tc) w_tx_state_nxt = c_ST_DATA;
            c_ST_DATA:  if (w_tx_tc && (r_tx_bit == 3'd7)) w_tx_state_nxt = c_ST_STOP;
            default:    if (w_tx_tc) w_tx_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_byte <= '0;
            r_tx_bit  <= '0;
            r_tx_done <= 1'b0;
        end else begin
            if (w_tx_accept) begin
                r_tx_byte <= WriteData[7:0];
                r_tx_bit  <= '0;
            end else if ((r_tx_state == c_ST_DATA) && w_tx_tc) begin
                r_tx_bit <= r_tx_bit + 3'd1;
            end
            if ((r_tx_state == c_ST_STOP) && w_tx_tc) r_tx_done <= 1'b1;
            else if (w_tx_accept || (w_con_wr && WriteData[c_CON_TXDONE_CLR])) r_tx_done <= 1'b0;
        end
    end

    // Decoded straight from state so an async reset forces the line idle at once.
    always_comb begin
        uart_tx = 1'b1;
        case (r_tx_state)
            c_ST_START: uart_tx = 1'b0;
            c_ST_DATA:  uart_tx = r_tx_byte[r_tx_bit];
            default:    uart_tx = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Restarting on the start-bit midpoint makes every later tc land mid-bit.
    assign w_rx_restart = (r_rx_state == c_ST_IDLE) | ((r_rx_state == c_ST_START) & w_rx_half);
    assign w_rx_stop_ok = (r_rx_state == c_ST_STOP) & w_rx_tc & r_rx_sync;

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
        .clk       (clk),
        .reset     (reset),
        .i_restart (w_rx_restart),
        .o_tc      (w_rx_tc),
        .o_half    (w_rx_half)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rx_state <= c_ST_IDLE;
        else        r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            c_ST_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_state_nxt = c_ST_START;
            c_ST_START: if (w_rx_half) w_rx_state_nxt = r_rx_sync ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:  if (w_rx_tc && (r_rx_bit == 3'd7)) w_rx_state_nxt = c_ST_STOP;
            default:    if (w_rx_tc) w_rx_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_irq_en   <= '0;
        end else begin
            if (r_rx_state == c_ST_IDLE) begin
                r_rx_bit <= '0;
            end else if ((r_rx_state == c_ST_DATA) && w_rx_tc) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
            if (w_rx_stop_ok) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (w_rxd_rd) begin
                r_rx_valid <= 1'b0;
            end
            // A byte landing on the same edge as the RXD read replaces it cleanly.
            if (w_rx_stop_ok && r_rx_valid && !w_rxd_rd) r_overrun <= 1'b1;
            else if (w_con_wr && WriteData[c_CON_OVERRUN]) r_overrun <= 1'b0;
            if (w_con_wr) r_irq_en <= WriteData[1:0];
        end
    end

    // ---------------- bus read / irq ----------------
    always_comb begin
        w_con_word = '0;
        w_con_word[c_CON_IRQ_RX]   = r_irq_en[0];
        w_con_word[c_CON_IRQ_TX]   = r_irq_en[1];
        w_con_word[c_CON_RX_VALID] = r_rx_valid;
        w_con_word[c_CON_TX_BUSY]  = w_tx_busy;
        w_con_word[c_CON_OVERRUN]  = r_overrun;
    end

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            if (w_hit_rxd)      ReadData = {24'b0, r_rx_data};
            else if (w_hit_con) ReadData = w_con_word;
        end
    end

    assign irq = (r_irq_en[0] & r_rx_valid) | (r_irq_en[1] & r_tx_done);

endmodule
`default_nettype wire

// File: tb/tb_uart_peripheral.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_peripheral                                                   |
// | Scoreboard bench: bus reads and TX frames checked against a model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_peripheral;

    localparam int          CPB   = 4;
    localparam logic [31:0] c_TXD = 32'h4000_0018;
    localparam logic [31:0] c_RXD = 32'h4000_001C;
    localparam logic [31:0] c_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ReadData;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        irq;

    uart_peripheral #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h4000_0018)) dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];
    bit         tx_mon_en = 1'b1;

    // Reference model state
    logic [7:0] m_data  = '0;
    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;
    logic [1:0] m_en    = '0;
    int         busy_end = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A frame accepted at edge E keeps the transmitter busy while cyc is E..E+39.
    function automatic logic [31:0] con_model();
        bit busy;
        busy = (cyc < busy_end - 1);
        return {27'b0, m_ovr, busy, m_valid, m_en};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Addr = a; WriteData = d; MemWrite = 1'b1;
        idle(1);
        MemWrite = 1'b0; Addr = '0; WriteData = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.exp = exp; e.name = name;
        rd_q.push_back(e);
        Addr = a; MemRead = 1'b1;
        idle(1);
        MemRead = 1'b0; Addr = '0;
    endtask

    task automatic rd_con(input string name);
        bus_read(c_CON, con_model(), name);
    endtask

    task automatic rd_rxd(input string name);
        bus_read(c_RXD, {24'b0, m_data}, name);
        m_valid = 1'b0;
    endtask

    task automatic con_write(input logic [31:0] d);
        bus_write(c_CON, d);
        m_en = d[1:0];
        if (d[4]) m_ovr = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b);
        if (cyc + 1 >= busy_end) begin
            tx_q.push_back(b);
            busy_end = cyc + 1 + 41;
        end
        bus_write(c_TXD, {24'b0, b});
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(CPB);
        end
        uart_rx = stop;
        idle(CPB);
        uart_rx = 1'b1;
        idle(4);
        if (stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_data  = b;
            m_valid = 1'b1;
        end
    endtask

    // Bus read monitor
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (MemRead) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_unexpected: got 0x%08h, expected no read", ReadData);
                end else begin
                    e = rd_q.pop_front();
                    chk(e.name, ReadData, e.exp);
                end
            end
        end
    end

    // Serial line monitor: decodes each frame and compares with the expected byte
    initial begin
        logic [9:0] f;
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (tx_mon_en && reset && (uart_tx == 1'b0)) begin
                f[0] = uart_tx;
                for (int k = 1; k < 10; k++) begin
                    repeat (CPB) @(negedge clk);
                    f[k] = uart_tx;
                end
                if (tx_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_unexpected_frame: got frame bits %b, expected no frame", f);
                end else begin
                    eb = tx_q.pop_front();
                    chk("tx_frame", {22'b0, f}, {22'b0, 1'b1, eb, 1'b0});
                end
            end
        end
    end

    initial begin
        #400000;
        n_checks++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        logic [7:0] b;
        idle(3);
        chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_readdata", ReadData, 32'd0);
        reset = 1'b1;
        idle(2);
        rd_con("con_after_reset");

        // TX 0xA5 with tx irq enabled
        con_write(32'h2);
        tx_write(8'hA5);
        idle(39);
        rd_con("con_busy_cycle40");
        rd_con("con_idle_cycle41");
        chk("irq_tx_done", {31'b0, irq}, 32'd1);
        con_write(32'h22);
        chk("irq_tx_done_cleared", {31'b0, irq}, 32'd0);

        // Second write while busy is dropped
        tx_write(8'h3C);
        idle(7);
        tx_write(8'hFF);
        idle(50);
        rd_con("con_after_discard");

        // RX single byte
        con_write(32'h0);
        send_rx(8'h5A, 1'b1);
        rd_con("con_rx_valid");
        rd_rxd("rxd_5a");
        rd_con("con_rx_cleared");

        // Overrun and rx irq
        con_write(32'h1);
        send_rx(8'h11, 1'b1);
        chk("irq_rx", {31'b0, irq}, 32'd1);
        send_rx(8'h22, 1'b1);
        rd_con("con_overrun");
        rd_rxd("rxd_overwritten");
        con_write(32'h11);
        rd_con("con_overrun_cleared");
        chk("irq_rx_cleared", {31'b0, irq}, 32'd0);

        // One-cycle glitch
        uart_rx = 1'b0;
        idle(1);
        uart_rx = 1'b1;
        idle(12);
        rd_con("con_after_glitch");

        // Framing error
        send_rx(8'hC3, 1'b0);
        rd_con("con_after_framing");
        rd_rxd("rxd_after_framing");

        // Random RX traffic
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send_rx(b, ($urandom_range(0, 3) != 0));
            rd_con("rand_rx_con");
            if ($urandom_range(0, 1) != 0) rd_rxd("rand_rx_data");
        end
        con_write(32'h10);

        // Random TX traffic, some writes land while busy
        for (int i = 0; i < 10; i++) begin
            tx_write(8'($urandom));
            idle(int'($urandom_range(2, 50)));
        end
        idle(60);

        // Reset in the middle of a frame
        con_write(32'h3);
        send_rx(8'h77, 1'b1);
        tx_mon_en = 1'b0;
        bus_write(c_TXD, 32'h0);
        idle(14);
        chk("tx_low_before_reset", {31'b0, uart_tx}, 32'd0);
        reset = 1'b0;
        #1;
        chk("tx_high_in_reset", {31'b0, uart_tx}, 32'd1);
        m_valid = 1'b0; m_ovr = 1'b0; m_en = '0; busy_end = 0;
        rd_con("con_in_reset");
        chk("irq_in_reset", {31'b0, irq}, 32'd0);
        reset = 1'b1;
        idle(2);
        tx_mon_en = 1'b1;
        rd_con("con_after_reset2");
        b = 8'($urandom);
        tx_write(b);
        idle(39);
        rd_con("con_busy_c40_after_rst");
        rd_con("con_idle_c41_after_rst");
        idle(20);

        chk("tx_queue_drained", tx_q.size(), 32'd0);
        chk("rd_queue_drained", rd_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
